// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issues one operation at a time to one of four execution units (arith,
// logic, cmp, shift), waits for that unit's result flag (bounded by TIMEOUT
// cycles), then holds the captured result until the consumer takes it.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         request handshake; in_a, in_b operands, in_fun
//                             ([3:2] unit select, [1:0] unit function)
//   op_a, op_b, unit_fn       registered operands/function to all units
//   *_en                      per-unit enables (at most one high)
//   *_flag, *_out             per-unit result-valid flags and results
//   res_valid/res_ready       result handshake; res_out, res_unit, timeout_err
//   dbg_state                 current FSM state (IDLE=0 ISSUE=1 WAIT=2 HOLD=3)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is high only in IDLE; res_valid is high only in HOLD
// and its payload is stable until the transfer.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_fun,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        unit_fn,
  output logic              arith_en,
  output logic              logic_en,
  output logic              cmp_en,
  output logic              shift_en,
  input  logic              arith_flag,
  input  logic              logic_flag,
  input  logic              cmp_flag,
  input  logic              shift_flag,
  input  logic [DATA_W-1:0] arith_out,
  input  logic [DATA_W-1:0] logic_out,
  input  logic [DATA_W-1:0] cmp_out,
  input  logic [DATA_W-1:0] shift_out,
  output logic [DATA_W-1:0] res_out,
  output logic [1:0]        res_unit,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Last WAIT count value before the operation is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [1:0]        fn_q, fn_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;

  logic              sel_flag;
  logic [DATA_W-1:0] sel_out;
  logic              busy;

  // Only the selected unit's flag/result is observed; others are ignored.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (sel_q)
      2'd0:    begin sel_flag = arith_flag; sel_out = arith_out; end
      2'd1:    begin sel_flag = logic_flag; sel_out = logic_out; end
      2'd2:    begin sel_flag = cmp_flag;   sel_out = cmp_out;   end
      default: begin sel_flag = shift_flag; sel_out = shift_out; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    fn_d    = fn_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          fn_d    = in_fun[1:0];
          sel_d   = in_fun[3:2];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sel_flag) begin
          res_d   = sel_out;
          err_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (res_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      fn_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      fn_q    <= fn_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Enables are decoded from registered state, so an asynchronous reset
  // drops them immediately.
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign arith_en    = busy && (sel_q == 2'd0);
  assign logic_en    = busy && (sel_q == 2'd1);
  assign cmp_en      = busy && (sel_q == 2'd2);
  assign shift_en    = busy && (sel_q == 2'd3);

  assign in_ready    = (state_q == IDLE);
  assign res_valid   = (state_q == HOLD);
  assign timeout_err = err_q && (state_q == HOLD);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign unit_fn     = fn_q;
  assign res_out     = res_q;
  assign res_unit    = sel_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int DW  = 16;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [3:0]    in_fun = '0;
  logic [DW-1:0] op_a, op_b;
  logic [1:0]    unit_fn;
  logic          arith_en, logic_en, cmp_en, shift_en;
  logic [3:0]    flag_v;
  logic [DW-1:0] out_v [4];
  logic [DW-1:0] res_out;
  logic [1:0]    res_unit;
  logic          res_valid, res_ready = 1'b0, timeout_err;
  logic [1:0]    dbg_state;

  alu_issue_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_fun(in_fun),
    .op_a(op_a), .op_b(op_b), .unit_fn(unit_fn),
    .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
    .arith_flag(flag_v[0]), .logic_flag(flag_v[1]), .cmp_flag(flag_v[2]), .shift_flag(flag_v[3]),
    .arith_out(out_v[0]), .logic_out(out_v[1]), .cmp_out(out_v[2]), .shift_out(out_v[3]),
    .res_out(res_out), .res_unit(res_unit), .res_valid(res_valid), .res_ready(res_ready),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unit behaviour: what each function of each unit computes.
  function automatic logic [DW-1:0] unit_f(input logic [1:0] u, input logic [1:0] fn,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb, r;
    sa = a;
    sb = b;
    r  = '0;
    case (u)
      2'd0: case (fn) 2'd0: r = a + b; 2'd1: r = a - b; 2'd2: r = -a; default: r = b - a; endcase
      2'd1: case (fn) 2'd0: r = a & b; 2'd1: r = a | b; 2'd2: r = a ^ b; default: r = ~a; endcase
      2'd2: case (fn)
              2'd0: r = {15'd0, sa < sb};
              2'd1: r = {15'd0, a == b};
              2'd2: r = {15'd0, a < b};
              default: r = {15'd0, sa > sb};
            endcase
      default: case (fn)
              2'd0: r = a << b[3:0];
              2'd1: r = a >> b[3:0];
              2'd2: r = sa >>> b[3:0];
              default: r = {a[14:0], a[15]};
            endcase
    endcase
    return r;
  endfunction

  // ---------------- unit environment ----------------
  // The enabled unit raises its flag once it has seen its enable for more
  // than cur_delay cycles; non-enabled units toggle random flags/results.
  int   cur_delay = 0;
  int   ecnt = 0;
  logic beef = 1'b0;
  logic [3:0] en_v;
  assign en_v = {shift_en, cmp_en, logic_en, arith_en};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_v <= '0;
      ecnt   <= 0;
    end else begin
      if (en_v != 4'd0) ecnt <= ecnt + 1;
      else              ecnt <= 0;
      for (int u = 0; u < 4; u++) begin
        if (en_v[u]) begin
          if (ecnt >= cur_delay) begin
            flag_v[u] <= 1'b1;
            out_v[u]  <= unit_f(2'(u), unit_fn, op_a, op_b);
          end else begin
            flag_v[u] <= 1'b0;
            out_v[u]  <= 16'($urandom);
          end
        end else if (beef && u == 1) begin
          flag_v[u] <= 1'b1;
          out_v[u]  <= 16'hBEEF;
        end else begin
          flag_v[u] <= 1'($urandom);
          out_v[u]  <= 16'($urandom);
        end
      end
    end
  end

  // res_ready changes just after the rising edge so it is stable at negedge.
  logic force_low = 1'b0, force_hi = 1'b0;
  always @(posedge clk) begin
    #1;
    res_ready = force_low ? 1'b0 : (force_hi ? 1'b1 : ($urandom_range(0, 2) != 0));
  end

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];   // {res_out, res_unit, timeout_err}
  int          lat_q[$];   // edges from accept to first res_valid
  int          acc_q[$];   // edge number of the accept
  int          last_acc = 0;

  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] fun, input int delay, input bit keep);
    bit done;
    @(negedge clk);
    in_a = a; in_b = b; in_fun = fun; in_valid = 1'b1;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      if (t != 0) @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    // Accept happens at the coming rising edge.
    cur_delay = delay;
    last_acc  = cyc + 1;
    if (delay <= TMO - 1) begin
      exp_q.push_back({unit_f(fun[3:2], fun[1:0], a, b), fun[3:2], 1'b0});
      lat_q.push_back(2 + delay);
    end else begin
      exp_q.push_back({16'd0, fun[3:2], 1'b1});
      lat_q.push_back(1 + TMO);
    end
    acc_q.push_back(last_acc);
    @(posedge clk);
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  // ---------------- monitor ----------------
  bit          seen = 0;
  logic [18:0] snap;
  always @(negedge clk) begin
    if (rst) begin
      chk("enable_onehot", 32'($countones(en_v) <= 1), 1);
      if (in_ready) chk("idle_quiet", {31'd0, (en_v != 4'd0) || res_valid}, 0);
      if (res_valid && !seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 0, 1);
        end else begin
          logic [18:0] e;
          int l, ac;
          e  = exp_q.pop_front();
          l  = lat_q.pop_front();
          ac = acc_q.pop_front();
          chk("result", {13'd0, res_out, res_unit, timeout_err}, {13'd0, e});
          chk("latency", cyc - ac, l);
        end
        seen = 1;
        snap = {res_out, res_unit, timeout_err};
      end else if (res_valid && seen) begin
        chk("hold_stable", {13'd0, res_out, res_unit, timeout_err}, {13'd0, snap});
      end
      if (res_valid && res_ready) seen = 0;
    end else begin
      seen = 0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int a1, a2, a3;
    bit ok;
    // Reset state.
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_enables", {28'd0, en_v}, 0);
    chk("rst_regs", {op_a, op_b}, 0);
    chk("rst_res", {13'd0, res_out, res_unit, timeout_err}, 0);
    chk("rst_fn", {30'd0, unit_fn}, 0);
    @(negedge clk); #2 rst = 1'b1;

    // Equal compare returns 1 after two edges.
    do_op(16'd5, 16'd5, 4'b1001, 0, 0);
    drain();

    // Consumer stalls: result held, no new accept.
    force_low = 1'b1;
    do_op(16'hFFFD, 16'd2, 4'b1011, 1, 0);
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
    end
    chk("stall_reach_hold", {31'd0, ok}, 1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, res_valid}, 1);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
    end
    force_low = 1'b0;
    drain();

    // Arith unit never answers: timeout after TMO WAIT cycles.
    do_op(16'd7, 16'd9, 4'b0000, 255, 0);
    drain();

    // Logic unit shouts BEEF while cmp is selected.
    beef = 1'b1;
    do_op(16'h0003, 16'h8000, 4'b1000, 2, 0);
    drain();
    beef = 1'b0;

    // Reset in the middle of WAIT.
    do_op(16'd1, 16'd2, 4'b0101, 255, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_enables", {28'd0, en_v}, 0);
    chk("midrst_res_valid", {31'd0, res_valid}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_op_a", {16'd0, op_a}, 0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    @(negedge clk); #2 rst = 1'b1;
    do_op(16'h00F0, 16'h0F0F, 4'b0110, 3, 0);
    drain();

    // Three back-to-back requests with in_valid held high.
    force_hi = 1'b1;
    do_op(16'd10, 16'd3, 4'b0001, 0, 1); a1 = last_acc;
    do_op(16'h1234, 16'h00FF, 4'b0100, 0, 1); a2 = last_acc;
    do_op(16'h8001, 16'd4, 4'b1110, 0, 1); a3 = last_acc;
    @(negedge clk); in_valid = 1'b0;
    chk("b2b_gap1", a2 - a1, 4);
    chk("b2b_gap2", a3 - a2, 4);
    drain();
    force_hi = 1'b0;

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      do_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, TMO + 1), 1'($urandom_range(0, 1)));
    end
    @(negedge clk); in_valid = 1'b0;
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
